riscv_div_seq: RTL and testbench

//  Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU; inverse datapath of riscv_mult.

---
 rtl/riscv_div_seq_pkg.sv | 27 ++
 rtl/riscv_div_lzc.sv | 23 ++
 rtl/riscv_div_seq.sv | 185 ++++++++++++++++++
 tb/tb_riscv_div_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_div_seq_pkg.sv
// Shared definitions for the sequential divider: operator encodings,
// FSM state type and small operator-decoding helpers.
package riscv_defines;

    localparam logic [1:0] DIV_DIV  = 2'b00;
    localparam logic [1:0] DIV_DIVU = 2'b01;
    localparam logic [1:0] DIV_REM  = 2'b10;
    localparam logic [1:0] DIV_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ITER   = 2'b01,
        SIGN   = 2'b10,
        FINISH = 2'b11
    } div_state_t;

    // DIV and REM are the signed variants (bit 0 clear).
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // REM and REMU return the remainder (bit 1 set).
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/riscv_div_lzc.sv
// Combinational leading-zero counter used by the divider's early-out path.
// An all-zero input reports WIDTH-1 so at least one iteration always runs.
module riscv_div_lzc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [$clog2(WIDTH)-1:0] lz_o
);

    localparam int CNT_W = $clog2(WIDTH);

    // Scan upward so the highest set bit determines the count.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        lz_o = CNT_W'(WIDTH - 1);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                lz_o = CNT_W'(WIDTH - 1 - i);
            end
        end
    end

endmodule

// File: rtl/riscv_div_seq.sv
// Multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Shares the EX-stage stall handshake with the multiplier: ready_o drops on
// accept, multicycle_o flags busy states, result_o is held in FINISH until
// ex_ready_i. Divide-by-zero and signed overflow finish in one cycle.
// Build option: define DIV_EARLY_OUT_EN to skip the leading zeros of the
// dividend magnitude (fewer ITER cycles, identical results).
import riscv_defines::*;

module riscv_div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic [1:0]       operator_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] result_o,
    output logic             multicycle_o,
    output logic             ready_o,
    input  logic             ex_ready_i
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t         state_q,  state_d;
    logic [1:0]         op_q,     op_d;
    logic               a_neg_q,  a_neg_d;
    logic               b_neg_q,  b_neg_d;
    logic [WIDTH-1:0]   div_q,    div_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   quo_q,    quo_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    // Operand decode on the incoming request.
    logic               in_signed;
    logic               in_a_neg;
    logic               in_b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               b_is_zero;
    logic               is_ovf;
    logic [WIDTH-1:0]   quo_init;
    logic [CNT_W-1:0]   cnt_init;

    assign in_signed = op_is_signed(operator_i);
    assign in_a_neg  = in_signed & op_a_i[WIDTH-1];
    assign in_b_neg  = in_signed & op_b_i[WIDTH-1];
    assign abs_a     = in_a_neg ? -op_a_i : op_a_i;
    assign abs_b     = in_b_neg ? -op_b_i : op_b_i;
    assign b_is_zero = (op_b_i == '0);
    assign is_ovf    = in_signed & (op_a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&op_b_i);

`ifdef DIV_EARLY_OUT_EN
    logic [CNT_W-1:0] lz;

    riscv_div_lzc #(
        .WIDTH (WIDTH)
    ) u_lzc (
        .data_i (abs_a),
        .lz_o   (lz)
    );

    // Leading zeros of the dividend only ever produce zero quotient bits.
    assign quo_init = abs_a << lz;
    assign cnt_init = CNT_W'(WIDTH - 1) - lz;
`else
    assign quo_init = abs_a;
    assign cnt_init = CNT_W'(WIDTH - 1);
`endif

    // Restoring step: shift in the next dividend bit and try to subtract.
    logic [WIDTH:0]     trial;
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, div_q};

    // Sign correction applied to the unsigned magnitudes.
    logic               quo_neg;
    logic               rem_neg;
    logic [WIDTH-1:0]   quo_final;
    logic [WIDTH-1:0]   rem_final;

    assign quo_neg   = op_is_signed(op_q) & (a_neg_q ^ b_neg_q);
    assign rem_neg   = op_is_signed(op_q) & a_neg_q;
    assign quo_final = quo_neg ? -quo_q : quo_q;
    assign rem_final = rem_neg ? -rem_q : rem_q;

    // Next-state, datapath update and handshake outputs.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        a_neg_d      = a_neg_q;
        b_neg_d      = b_neg_q;
        div_d        = div_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        ready_o      = 1'b0;
        multicycle_o = 1'b0;

        case (state_q)
            IDLE: begin
                ready_o = ~enable_i;
                if (enable_i) begin
                    op_d    = operator_i;
                    a_neg_d = in_a_neg;
                    b_neg_d = in_b_neg;
                    div_d   = abs_b;
                    if (b_is_zero) begin
                        result_d = op_is_rem(operator_i) ? op_a_i : '1;
                        state_d  = FINISH;
                    end else if (is_ovf) begin
                        result_d = op_is_rem(operator_i) ? '0 : op_a_i;
                        state_d  = FINISH;
                    end else begin
                        rem_d   = '0;
                        quo_d   = quo_init;
                        cnt_d   = cnt_init;
                        state_d = ITER;
                    end
                end
            end
            ITER: begin
                multicycle_o = 1'b1;
                if (!trial[WIDTH]) begin
                    rem_d = trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == '0) begin
                    state_d = SIGN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SIGN: begin
                multicycle_o = 1'b1;
                result_d     = op_is_rem(op_q) ? rem_final : quo_final;
                state_d      = FINISH;
            end
            FINISH: begin
                ready_o = 1'b1;
                if (ex_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset too, so a reset mid-divide leaves no stale partial result visible.
            state_q  <= IDLE;
            op_q     <= '0;
            a_neg_q  <= 1'b0;
            b_neg_q  <= 1'b0;
            div_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            a_neg_q  <= a_neg_d;
            b_neg_q  <= b_neg_d;
            div_q    <= div_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_riscv_div_seq.sv
// Self-checking bench for riscv_div_seq: directed RV32M divide vectors
// checked cycle by cycle against an arithmetic reference model.
module tb_riscv_div_seq;

    localparam int WIDTH = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              enable_i;
    logic [1:0]        operator_i;
    logic [WIDTH-1:0]  op_a_i;
    logic [WIDTH-1:0]  op_b_i;
    logic [WIDTH-1:0]  result_o;
    logic              multicycle_o;
    logic              ready_o;
    logic              ex_ready_i;

    int n_tests = 0;
    int n_fail  = 0;

    // Shared with the compare process.
    bit               busy = 1'b0;
    logic [WIDTH-1:0] exp_result;
    int               exp_lat;
    int               cyc = 0;

    riscv_div_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .operator_i   (operator_i),
        .op_a_i       (op_a_i),
        .op_b_i       (op_b_i),
        .result_o     (result_o),
        .multicycle_o (multicycle_o),
        .ready_o      (ready_o),
        .ex_ready_i   (ex_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // RV32M semantics using plain integer arithmetic (truncating division).
    function automatic logic [WIDTH-1:0] model(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint sa, sb, q, r;
        logic   is_rem = op[1];
        if (b == 0) return is_rem ? a : '1;
        if (!op[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return is_rem ? r[WIDTH-1:0] : q[WIDTH-1:0];
        end
        return is_rem ? (a % b) : (a / b);
    endfunction

    // Cycles from accept until ready_o is expected high again.
    function automatic int lat_model(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic             sgn = ~op[0];
        logic [WIDTH-1:0] ma;
        int               bits;
        if (b == 0) return 1;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        ma   = (sgn && a[WIDTH-1]) ? -a : a;
        bits = 0;
        for (int i = 0; i < WIDTH; i++) if (ma[i]) bits = i + 1;
        if (bits == 0) bits = 1;
`ifdef DIV_EARLY_OUT_EN
        return bits + 2;
`else
        return WIDTH + 2;
`endif
    endfunction

    // Compare process: checks handshake and result on every cycle of a transaction.
    always @(negedge clk) begin
        if (busy) begin
            if (cyc == 0) begin
                check("accept_ready", 32'(ready_o), 32'd0);
                check("accept_multicycle", 32'(multicycle_o), 32'd0);
            end else if (cyc < exp_lat) begin
                check("busy_ready", 32'(ready_o), 32'd0);
                check("busy_multicycle", 32'(multicycle_o), 32'd1);
            end else begin
                check("finish_ready", 32'(ready_o), 32'd1);
                check("finish_multicycle", 32'(multicycle_o), 32'd0);
                check("finish_result", result_o, exp_result);
            end
            cyc++;
        end else begin
            cyc = 0;
        end
    end

    // Issue one operation, stall hold extra cycles in FINISH, optionally disturb inputs.
    task automatic run_op(input string name, input logic [1:0] op, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] lit,
                          input int hold, input bit toggle);
        check({"model_", name}, model(op, a, b), lit);
        @(posedge clk); #1;
        operator_i = op;
        op_a_i     = a;
        op_b_i     = b;
        enable_i   = 1'b1;
        ex_ready_i = 1'b0;
        exp_result = model(op, a, b);
        exp_lat    = lat_model(op, a, b);
        busy       = 1'b1;
        @(posedge clk); #1;
        enable_i = 1'b0;
        if (toggle) begin
            op_a_i     = ~a;
            op_b_i     = b + 32'd3;
            operator_i = ~op;
            enable_i   = 1'b1;
        end
        repeat (exp_lat - 1 + hold) @(posedge clk);
        #1;
        enable_i   = 1'b0;
        ex_ready_i = 1'b1;
        @(posedge clk); #1;
        ex_ready_i = 1'b0;
        busy       = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable_i   = 1'b0;
        operator_i = 2'b00;
        op_a_i     = '0;
        op_b_i     = '0;
        ex_ready_i = 1'b0;
        #2;
        check("reset_ready", 32'(ready_o), 32'd1);
        check("reset_multicycle", 32'(multicycle_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        #10 rst_n = 1'b1;

`ifndef DIV_EARLY_OUT_EN
        check("lat_model_full", 32'(lat_model(2'b01, 32'd100, 32'd7)), 32'd34);
`endif
        check("lat_model_div0", 32'(lat_model(2'b00, 32'hFFFF_FFFB, 32'd0)), 32'd1);

        run_op("divu_100_7",   2'b01, 32'd100,        32'd7,          32'd14,         0, 1'b0);
        run_op("remu_100_7",   2'b11, 32'd100,        32'd7,          32'd2,          0, 1'b0);
        run_op("div_m7_2",     2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  0, 1'b0);
        run_op("rem_m7_2",     2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  0, 1'b0);
        run_op("div_7_m2",     2'b00, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  0, 1'b0);
        run_op("rem_7_m2",     2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          0, 1'b0);
        run_op("divu_5_0",     2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  0, 1'b0);
        run_op("remu_5_0",     2'b11, 32'd5,          32'd0,          32'd5,          0, 1'b0);
        run_op("div_m5_0",     2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  0, 1'b0);
        run_op("rem_m5_0",     2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  0, 1'b0);
        run_op("div_ovf",      2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0, 1'b0);
        run_op("rem_ovf",      2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 1'b0);
        run_op("divu_1_1",     2'b01, 32'd1,          32'd1,          32'd1,          0, 1'b0);
        run_op("divu_max_1",   2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  0, 1'b0);
        run_op("div_min_1",    2'b00, 32'h8000_0000,  32'd1,          32'h8000_0000,  0, 1'b0);
        run_op("divu_min_m1",  2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0, 1'b0);
        run_op("remu_max_16",  2'b11, 32'hFFFF_FFFF,  32'd16,         32'd15,         0, 1'b0);
        run_op("divu_0_5",     2'b01, 32'd0,          32'd5,          32'd0,          0, 1'b0);
        run_op("rem_m100_m7",  2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  0, 1'b0);
        // Stall in FINISH with the inputs wiggling; result must not move.
        run_op("divu_hold",    2'b01, 32'd100,        32'd7,          32'd14,        10, 1'b1);
        run_op("div0_hold",    2'b00, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFF,  4, 1'b1);

        // Reset in the middle of an iteration sequence.
        @(posedge clk); #1;
        operator_i = 2'b01;
        op_a_i     = 32'd100;
        op_b_i     = 32'd7;
        enable_i   = 1'b1;
        @(posedge clk); #1;
        enable_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_iter_multicycle", 32'(multicycle_o), 32'd1);
        check("mid_iter_ready", 32'(ready_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", 32'(ready_o), 32'd1);
        check("rst_mid_multicycle", 32'(multicycle_o), 32'd0);
        check("rst_mid_result", result_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("post_rst_ready", 32'(ready_o), 32'd1);
        check("post_rst_result", result_o, 32'd0);

        run_op("divu_1_1_post", 2'b01, 32'd1,         32'd1,          32'd1,          0, 1'b0);
        run_op("remu_100_7_b",  2'b11, 32'd100,       32'd7,          32'd2,          2, 1'b0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
